reg_bank_mp: RTL and testbench

Parametrised multi-port register bank, the successor of the single-write/dual-read bank in the CPU datapath. Provides N_RD combinational read ports, two prioritised write ports with byte enables, optional write-to-read bypass and an optional hardwired zero register. A sequential clear engine zeroes the array one entry per cycle on command, so a full wipe does not need a reset.

---
 rtl/regbank_pkg.sv | 31 +++
 rtl/reg_bank_clr_fsm.sv | 67 ++++++
 rtl/reg_bank_mp.sv | 97 +++++++++
 tb/tb_reg_bank_mp.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
// regbank_pkg: shared clear-FSM state type and byte-merge helper for reg_bank_mp.
// Revision: 1.0
// ============================================================================
package regbank_pkg;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < MAX_BE_W; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_clr_fsm.sv
`default_nettype none
// ============================================================================
// reg_bank_clr_fsm: sequential clear engine, one entry per cycle, plus wr_drop flag.
// Revision: 1.0
// ============================================================================
module reg_bank_clr_fsm
  import regbank_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_start_i,
  input  logic              wr_req_i,
  output logic              busy_o,
  output logic              wr_drop_o,
  output logic              clear_we_o,
  output logic [ADDR_W-1:0] clear_addr_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  clr_state_e      state_q;
  logic [ADDR_W:0] index_q;
  logic            busy_q;
  logic            wr_drop_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      // Any effective write request seen while busy was discarded by the array.
      wr_drop_q <= busy_q && wr_req_i;
      case (state_q)
        ST_IDLE: begin
          if (clear_start_i) begin
            state_q <= ST_CLEAR;
            index_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          index_q <= index_q + 1'b1;
          if (index_q == LAST_IDX) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign wr_drop_o    = wr_drop_q;
  assign clear_we_o   = (state_q == ST_CLEAR);
  assign clear_addr_o = index_q[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: rtl/reg_bank_mp.sv
`default_nettype none
// ============================================================================
// reg_bank_mp: multi-read, dual prioritised byte-enable write register bank with clear engine.
// Revision: 1.0
// ============================================================================
module reg_bank_mp
  import regbank_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_RD*ADDR_W-1:0]   sr,
  output logic [N_RD*DATA_W-1:0]   rddata,
  input  logic                     write0,
  input  logic [ADDR_W-1:0]        dr0,
  input  logic [DATA_W-1:0]        wrdata0,
  input  logic [DATA_W/8-1:0]      be0,
  input  logic                     write1,
  input  logic [ADDR_W-1:0]        dr1,
  input  logic [DATA_W-1:0]        wrdata1,
  input  logic [DATA_W/8-1:0]      be1,
  input  logic                     clear_start,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              blk0, blk1;
  logic              we0, we1;
  logic              wr_req;
  logic              clear_we;
  logic [ADDR_W-1:0] clear_addr;
  logic [BE_W-1:0]   be0_hit, be1_hit;

  // Writes to a hardwired zero entry vanish without counting as drops.
  assign blk0   = (ZERO_REG != 0) && (dr0 == '0);
  assign blk1   = (ZERO_REG != 0) && (dr1 == '0);
  assign we0    = write0 && !busy && !blk0;
  assign we1    = write1 && !busy && !blk1;
  assign wr_req = (write0 && (|be0) && !blk0) || (write1 && (|be1) && !blk1);

  reg_bank_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear_start_i (clear_start),
    .wr_req_i      (wr_req),
    .busy_o        (busy),
    .wr_drop_o     (wr_drop),
    .clear_we_o    (clear_we),
    .clear_addr_o  (clear_addr)
  );

  // Port 1 is merged first so port 0 bytes overwrite it on a shared address.
  always_comb begin
    be0_hit = '0;
    be1_hit = '0;
    for (int e = 0; e < DEPTH; e++) begin
      be0_hit  = (we0 && (dr0 == ADDR_W'(e))) ? be0 : '0;
      be1_hit  = (we1 && (dr1 == ADDR_W'(e))) ? be1 : '0;
      mem_d[e] = DATA_W'(merge_bytes(
                   merge_bytes(MAX_DATA_W'(mem_q[e]), MAX_DATA_W'(wrdata1), MAX_BE_W'(be1_hit)),
                   MAX_DATA_W'(wrdata0), MAX_BE_W'(be0_hit)));
      if (clear_we && (clear_addr == ADDR_W'(e))) mem_d[e] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Next-state view doubles as the bypass path; it carries no clear term when idle.
  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = sr[i*ADDR_W +: ADDR_W];
    assign rddata[i*DATA_W +: DATA_W] =
      ((ZERO_REG != 0) && (ra == '0)) ? '0 :
      ((BYPASS != 0) && !busy)        ? mem_d[ra] : mem_q[ra];
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_mp.sv
`default_nettype none
// ============================================================================
// tb_reg_bank_mp: vector table, directed clear/reset sequences and random traffic vs a model.
// Revision: 1.0
// ============================================================================
module tb_reg_bank_mp;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  sr0 = '0, sr1 = '0;
  logic [9:0]  sr;
  logic [63:0] rddata;
  logic        write0 = 1'b0, write1 = 1'b0, clear_start = 1'b0;
  logic [4:0]  dr0 = '0, dr1 = '0;
  logic [31:0] wrdata0 = '0, wrdata1 = '0;
  logic [3:0]  be0 = '0, be1 = '0;
  logic        busy, wr_drop;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  assign sr = {sr1, sr0};

  always #5 clk = ~clk;

  reg_bank_mp #(
    .DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sr(sr), .rddata(rddata),
    .write0(write0), .dr0(dr0), .wrdata0(wrdata0), .be0(be0),
    .write1(write1), .dr1(dr1), .wrdata1(wrdata1), .be1(be1),
    .clear_start(clear_start), .busy(busy), .wr_drop(wr_drop)
  );

  // Reference model: word array, remaining clear cycles, expected drop flag.
  logic [31:0] m [32];
  int          busy_left = 0;
  logic        exp_drop = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic logic [31:0] merged(input logic [4:0] a);
    logic [31:0] w;
    w = m[a];
    for (int b = 0; b < 4; b++) begin
      if (write1 && dr1 == a && be1[b]) w[b*8 +: 8] = wrdata1[b*8 +: 8];
      if (write0 && dr0 == a && be0[b]) w[b*8 +: 8] = wrdata0[b*8 +: 8];
    end
    return w;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (busy_left == 0) return merged(a);
    return m[a];
  endfunction

  task automatic model_edge();
    logic        nd;
    logic [31:0] nm [32];
    nd = (busy_left > 0) && ((write0 && be0 != 4'h0 && dr0 != 5'd0) ||
                             (write1 && be1 != 4'h0 && dr1 != 5'd0));
    if (busy_left > 0) begin
      m[32 - busy_left] = 32'h0;
      busy_left--;
    end else begin
      for (int a = 1; a < 32; a++) nm[a] = merged(5'(a));
      for (int a = 1; a < 32; a++) m[a] = nm[a];
      if (clear_start) busy_left = 32;
    end
    exp_drop = nd;
  endtask

  task automatic model_reset();
    for (int a = 0; a < 32; a++) m[a] = 32'h0;
    busy_left = 0;
    exp_drop  = 1'b0;
  endtask

  task automatic chk_now();
    chk("rd0", rddata[31:0], exp_rd(sr0));
    chk("rd1", rddata[63:32], exp_rd(sr1));
    chk("busy", 32'(busy), 32'(busy_left > 0));
    chk("wr_drop", 32'(wr_drop), 32'(exp_drop));
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    chk_now();
    edge_step();
  endtask

  task automatic idle_inputs();
    write0 = 1'b0; write1 = 1'b0; clear_start = 1'b0;
    be0 = 4'h0; be1 = 4'h0;
  endtask

  typedef struct {
    logic        w0; logic [4:0] d0; logic [31:0] wd0; logic [3:0] b0;
    logic        w1; logic [4:0] d1; logic [31:0] wd1; logic [3:0] b1;
    logic [4:0]  s0; logic [4:0] s1; logic [31:0] e0; logic [31:0] e1;
  } vec_t;

  vec_t tbl [12];
  int   nb;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 5'd3, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 32'h0,        4'h0, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 32'h0,        4'h0, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0};
    tbl[2]  = '{1'b1, 5'd5, 32'h11223344, 4'hF, 1'b0, 5'd0, 32'h0,        4'h0, 5'd5, 5'd3, 32'h11223344, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd5, 32'hAABBCCDD, 4'h5, 5'd3, 5'd5, 32'hDEADBEEF, 32'h11BB33DD};
    tbl[4]  = '{1'b1, 5'd7, 32'h000000FF, 4'h1, 1'b1, 5'd7, 32'hFFFFFF00, 4'hF, 5'd7, 5'd5, 32'hFFFFFFFF, 32'h11BB33DD};
    tbl[5]  = '{1'b1, 5'd7, 32'h0,        4'hF, 1'b0, 5'd0, 32'h0,        4'h0, 5'd7, 5'd0, 32'h0,        32'h0};
    tbl[6]  = '{1'b1, 5'd7, 32'h000000FF, 4'h1, 1'b1, 5'd7, 32'hFFFFFF00, 4'hE, 5'd7, 5'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[7]  = '{1'b1, 5'd7, 32'h0,        4'hF, 1'b0, 5'd0, 32'h0,        4'h0, 5'd0, 5'd7, 32'h0,        32'h0};
    tbl[8]  = '{1'b1, 5'd7, 32'h00000012, 4'h1, 1'b1, 5'd7, 32'hFFFFFF00, 4'hF, 5'd7, 5'd3, 32'hFFFFFF12, 32'hDEADBEEF};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 32'h0,        4'h0, 5'd7, 5'd5, 32'hFFFFFF12, 32'h11BB33DD};
    tbl[10] = '{1'b1, 5'd0, 32'h12345678, 4'hF, 1'b1, 5'd0, 32'h12345678, 4'hF, 5'd0, 5'd3, 32'h0,        32'hDEADBEEF};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 32'h0,        4'h0, 5'd0, 5'd7, 32'h0,        32'hFFFFFF12};

    // Reset state
    model_reset();
    #3;
    for (int a = 0; a < 4; a++) begin
      sr0 = 5'(a * 7 + 1); sr1 = 5'(31 - a);
      #1;
      chk("reset_rd0", rddata[31:0], 32'h0);
      chk("reset_rd1", rddata[63:32], 32'h0);
    end
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_wr_drop", 32'(wr_drop), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      write0 = tbl[i].w0; dr0 = tbl[i].d0; wrdata0 = tbl[i].wd0; be0 = tbl[i].b0;
      write1 = tbl[i].w1; dr1 = tbl[i].d1; wrdata1 = tbl[i].wd1; be1 = tbl[i].b1;
      sr0 = tbl[i].s0; sr1 = tbl[i].s1;
      @(negedge clk);
      chk($sformatf("tbl%0d_rd0", i), rddata[31:0], tbl[i].e0);
      chk($sformatf("tbl%0d_rd1", i), rddata[63:32], tbl[i].e1);
      chk($sformatf("tbl%0d_wr_drop", i), 32'(wr_drop), 32'h0);
      chk_now();
      edge_step();
    end
    idle_inputs();

    // Randomised traffic, including occasional clears
    for (int c = 0; c < 400; c++) begin
      write0 = 1'($urandom_range(0, 1));
      write1 = 1'($urandom_range(0, 1));
      dr0 = 5'($urandom_range(0, 31));
      dr1 = ($urandom_range(0, 3) == 0) ? dr0 : 5'($urandom_range(0, 31));
      wrdata0 = $urandom; wrdata1 = $urandom;
      be0 = 4'($urandom_range(0, 15)); be1 = 4'($urandom_range(0, 15));
      sr0 = ($urandom_range(0, 1) == 0) ? dr0 : 5'($urandom_range(0, 31));
      sr1 = ($urandom_range(0, 1) == 0) ? dr1 : 5'($urandom_range(0, 31));
      clear_start = ($urandom_range(0, 63) == 0);
      step();
    end
    idle_inputs();
    for (int c = 0; c < 40 && busy_left > 0; c++) step();

    // Full fill, then a clear with a write dropped on busy cycle 3
    for (int a = 0; a < 32; a++) begin
      write0 = 1'b1; dr0 = 5'(a); wrdata0 = $urandom | 32'h1; be0 = 4'hF;
      sr0 = 5'(a); sr1 = 5'd31;
      step();
    end
    idle_inputs();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      write0 = (c == 2); dr0 = 5'd9; wrdata0 = 32'hA5A5A5A5; be0 = 4'hF;
      sr0 = 5'd31; sr1 = 5'd9;
      @(negedge clk);
      if (busy) nb++;
      if (c == 3) chk("clr_wr_drop_pulse", 32'(wr_drop), 32'h1);
      if (c == 4) chk("clr_wr_drop_single", 32'(wr_drop), 32'h0);
      if (c == 31) chk("clr_e31_nonzero_last", 32'(rddata[31:0] != 32'h0), 32'h1);
      if (c == 32) chk("clr_busy_fell", 32'(busy), 32'h0);
      chk_now();
      edge_step();
    end
    idle_inputs();
    chk("clr_busy_cycles", 32'(nb), 32'd32);
    for (int a = 0; a < 32; a++) begin
      sr0 = 5'(a); sr1 = 5'(31 - a);
      @(negedge clk);
      chk("clr_all_zero", rddata[31:0] | rddata[63:32], 32'h0);
      chk_now();
      edge_step();
    end

    // Asynchronous reset in the middle of a clear
    for (int a = 1; a < 8; a++) begin
      write0 = 1'b1; dr0 = 5'(a); wrdata0 = 32'h5000_0000 + 32'(a); be0 = 4'hF;
      step();
    end
    idle_inputs();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int c = 0; c < 9; c++) step();
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_wr_drop", 32'(wr_drop), 32'h0);
    for (int a = 0; a < 32; a++) begin
      sr0 = 5'(a); sr1 = 5'(31 - a);
      #1;
      chk("arst_rd_zero", rddata[31:0] | rddata[63:32], 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    write0 = 1'b1; dr0 = 5'd4; wrdata0 = 32'hCAFEF00D; be0 = 4'hF;
    sr0 = 5'd4; sr1 = 5'd5;
    @(negedge clk);
    chk("post_rst_bypass", rddata[31:0], 32'hCAFEF00D);
    chk_now();
    edge_step();
    idle_inputs();
    @(negedge clk);
    chk("post_rst_read4", rddata[31:0], 32'hCAFEF00D);
    chk("post_rst_read5", rddata[63:32], 32'h0);
    chk_now();
    edge_step();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
`default_nettype wire
